// File: rtl/sram1rw_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram1rw_arb
// Purpose  : Round-robin arbiter and sequencer sharing one sram1rw
//            scratchpad bank between NREQ requesters. Grants at most one
//            aligned 1/2/4/8-byte access per cycle, drives the bank and
//            returns a one-cycle-latency response tagged with the
//            requester id. Misaligned or oversized accesses never reach
//            the bank and come back with an error response.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            req_valid/ready/we         - per-requester handshake and direction
//            req_size/addr/wdata        - packed per-requester access fields
//            rsp_valid/id/we/err/rdata  - response, one cycle after the grant
//            sram_addr/web/ibyte        - drive to the bank
//            sram_obyte                 - read data from the bank (lane-0 aligned)
// Revision : 1.0 - initial release
// ============================================================================
module sram1rw_arb #(
    parameter int W_WIDTH = 3,
    parameter int H_WIDTH = 8,
    parameter int NREQ    = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NREQ-1:0]                           req_valid,
    output logic [NREQ-1:0]                           req_ready,
    input  logic [NREQ-1:0]                           req_we,
    input  logic [2*NREQ-1:0]                         req_size,
    input  logic [NREQ*(H_WIDTH+W_WIDTH)-1:0]         req_addr,
    input  logic [NREQ*8*(1<<W_WIDTH)-1:0]            req_wdata,
    output logic                                      rsp_valid,
    output logic [IDW-1:0]                            rsp_id,
    output logic                                      rsp_we,
    output logic                                      rsp_err,
    output logic [8*(1<<W_WIDTH)-1:0]                 rsp_rdata,
    output logic [H_WIDTH+W_WIDTH-1:0]                sram_addr,
    output logic [W_WIDTH:0]                          sram_web,
    output logic [8*(1<<W_WIDTH)-1:0]                 sram_ibyte,
    input  logic [8*(1<<W_WIDTH)-1:0]                 sram_obyte
);

    localparam int C_N  = 1 << W_WIDTH;
    localparam int C_AW = H_WIDTH + W_WIDTH;
    localparam int C_DW = 8 * C_N;

    // ------------------------------------------------------------------
    // Per-requester field unpacking and legality
    // ------------------------------------------------------------------
    logic [1:0]      w_size  [NREQ];
    logic [C_AW-1:0] w_addr  [NREQ];
    logic [C_DW-1:0] w_wdata [NREQ];
    logic [C_AW-1:0] w_amask [NREQ];
    logic [NREQ-1:0] w_legal;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_size[gi]  = req_size[2*gi +: 2];
            assign w_addr[gi]  = req_addr[C_AW*gi +: C_AW];
            assign w_wdata[gi] = req_wdata[C_DW*gi +: C_DW];
            // Low 'size' address bits must be zero for a naturally aligned access.
            assign w_amask[gi] = ~({C_AW{1'b1}} << w_size[gi]);
            assign w_legal[gi] = ({30'd0, w_size[gi]} <= W_WIDTH) &&
                                 ((w_addr[gi] & w_amask[gi]) == '0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [IDW-1:0]  r_rr;
    logic            w_found;
    logic            w_grant;
    logic [IDW-1:0]  w_win;

    // Scan from the pointer upwards, wrapping modulo NREQ; the first
    // valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = int'(r_rr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(idx);
            end
        end
    end

    // No grants are issued while reset is held.
    assign w_grant   = w_found & rst_n;
    assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;

    logic [IDW-1:0] w_rr_next;
    assign w_rr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

    // ------------------------------------------------------------------
    // Winner fields and bank drive
    // ------------------------------------------------------------------
    logic            w_win_we;
    logic [1:0]      w_win_size;
    logic [C_AW-1:0] w_win_addr;
    logic [C_DW-1:0] w_win_wdata;
    logic            w_win_legal;
    logic            w_bank_go;
    logic [W_WIDTH:0] w_size_onehot;
    logic [C_AW-1:0] r_last_addr;

    assign w_win_we    = req_we[w_win];
    assign w_win_size  = w_size[w_win];
    assign w_win_addr  = w_addr[w_win];
    assign w_win_wdata = w_wdata[w_win];
    assign w_win_legal = w_legal[w_win];

    assign w_bank_go     = w_grant & w_win_legal;
    assign w_size_onehot = {{W_WIDTH{1'b0}}, 1'b1} << w_win_size;

    // Idle and rejected cycles keep the last legal address on the bus so
    // the address lines do not toggle needlessly.
    assign sram_addr  = w_bank_go ? w_win_addr : r_last_addr;
    assign sram_web   = (w_bank_go && w_win_we) ? ~w_size_onehot : '1;
    assign sram_ibyte = w_grant ? w_win_wdata : '0;

    // ------------------------------------------------------------------
    // Response pipeline register
    // ------------------------------------------------------------------
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_we;
    logic           r_rsp_err;
    logic [1:0]     r_rsp_size;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_last_addr <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_size  <= '0;
        end else begin
            r_rsp_valid <= w_grant;
            if (w_grant) begin
                r_rr       <= w_rr_next;
                r_rsp_id   <= w_win;
                r_rsp_we   <= w_win_we;
                r_rsp_err  <= ~w_win_legal;
                r_rsp_size <= w_win_size;
            end
            if (w_bank_go) begin
                r_last_addr <= w_win_addr;
            end
        end
    end

    // A reset asserted in the response cycle drops the pending response.
    assign rsp_valid = r_rsp_valid & rst_n;
    assign rsp_id    = rsp_valid ? r_rsp_id : '0;
    assign rsp_we    = rsp_valid & r_rsp_we;
    assign rsp_err   = rsp_valid & r_rsp_err;

    // Read data is lane-0 aligned from the bank; only the low 1<<size
    // lanes are kept, everything else is zero.
    logic w_rd_ok;
    assign w_rd_ok = rsp_valid & ~r_rsp_we & ~r_rsp_err;

    genvar gk;
    generate
        for (gk = 0; gk < C_N; gk++) begin : g_lane
            logic w_lane_en;
            assign w_lane_en = ((32'(gk) >> r_rsp_size) == 32'd0);
            assign rsp_rdata[8*gk +: 8] = (w_rd_ok && w_lane_en) ? sram_obyte[8*gk +: 8] : 8'h00;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram1rw_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram1rw_arb
// Purpose  : Directed self-checking bench for sram1rw_arb with a behavioural
//            sram1rw bank (replicated sub-word writes, lane-0 aligned reads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram1rw_arb;

    localparam int W    = 3;
    localparam int H    = 8;
    localparam int NREQ = 2;
    localparam int AW   = H + W;
    localparam int DW   = 64;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [3:0]      req_size;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_id;
    logic            rsp_we;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   sram_addr;
    logic [W:0]      sram_web;
    logic [DW-1:0]   sram_ibyte;
    logic [DW-1:0]   sram_obyte;

    int n_checks = 0;
    int n_pass   = 0;

    sram1rw_arb #(.W_WIDTH(W), .H_WIDTH(H), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_we     (rsp_we),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .sram_addr  (sram_addr),
        .sram_web   (sram_web),
        .sram_ibyte (sram_ibyte),
        .sram_obyte (sram_obyte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: registered lane-0 aligned read of the addressed
    // row, sub-word write of the low 1<<size bytes at the row offset.
    logic [7:0] mem [0:255][0:7];
    logic       bank_clear;

    always @(posedge clk) begin : bank_model
        int row;
        int off;
        int n;
        logic [63:0] rd;
        row = int'(sram_addr[AW-1:W]);
        off = int'(sram_addr[W-1:0]);
        for (int k = 0; k < 8; k++) rd[8*k +: 8] = mem[row][(off + k) % 8];
        sram_obyte <= rd;
        if (bank_clear) begin
            for (int r = 0; r < 256; r++)
                for (int b = 0; b < 8; b++) mem[r][b] <= 8'h00;
        end else if (sram_web != 4'hF) begin
            n = 0;
            for (int s = 0; s < 4; s++) if (!sram_web[s]) n = 1 << s;
            for (int j = 0; j < n; j++)
                if (off + j < 8) mem[row][off + j] <= sram_ibyte[8*j +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic we, input logic [1:0] sz,
                         input logic [AW-1:0] a, input logic [63:0] d);
        req_valid[i]            = v;
        req_we[i]               = we;
        req_size[2*i +: 2]      = sz;
        req_addr[AW*i +: AW]    = a;
        req_wdata[DW*i +: DW]   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        bank_clear = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_size   = '0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset: a pending request must not be granted.
        drive(0, 1'b1, 1'b0, 2'd3, 11'h010, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_web", 64'(sram_web), 64'hF);
        chk("rst_addr", 64'(sram_addr), 64'h0);
        chk("rst_rdata", rsp_rdata, 64'h0);
        chk("rst_id", 64'(rsp_id), 64'h0);
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        rst_n      = 1'b1;
        bank_clear = 1'b0;
        tick();
        chk("post_rst_valid", 64'(rsp_valid), 64'h0);

        // Preload row 0x10 with bytes 0x00..0x07.
        drive(0, 1'b1, 1'b1, 2'd3, 11'h010, 64'h0706050403020100);
        #1;
        chk("pre_ready", 64'(req_ready), 64'h1);
        chk("pre_web", 64'(sram_web), 64'h7);
        chk("pre_addr", 64'(sram_addr), 64'h010);
        chk("pre_ibyte", sram_ibyte, 64'h0706050403020100);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("pre_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("pre_rsp_we", 64'(rsp_we), 64'h1);
        chk("pre_rsp_err", 64'(rsp_err), 64'h0);
        chk("pre_rsp_rdata", rsp_rdata, 64'h0);

        // Full-row read.
        drive(0, 1'b1, 1'b0, 2'd3, 11'h010, 64'h0);
        #1;
        chk("rd8_ready", 64'(req_ready), 64'h1);
        chk("rd8_web", 64'(sram_web), 64'hF);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("rd8_valid", 64'(rsp_valid), 64'h1);
        chk("rd8_id", 64'(rsp_id), 64'h0);
        chk("rd8_we", 64'(rsp_we), 64'h0);
        chk("rd8_rdata", rsp_rdata, 64'h0706050403020100);

        // Half-word write from requester 1, read back two ways.
        drive(1, 1'b1, 1'b1, 2'd1, 11'h00A, 64'hBEEF);
        #1;
        chk("wr2_ready", 64'(req_ready), 64'h2);
        chk("wr2_web", 64'(sram_web), 64'hD);
        tick();
        drive(1, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("wr2_id", 64'(rsp_id), 64'h1);
        chk("wr2_we", 64'(rsp_we), 64'h1);
        drive(0, 1'b1, 1'b0, 2'd1, 11'h00A, 64'h0);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("rd2_rdata", rsp_rdata, 64'h000000000000BEEF);
        drive(1, 1'b1, 1'b0, 2'd3, 11'h008, 64'h0);
        tick();
        drive(1, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("rd8_row08_rdata", rsp_rdata, 64'h00000000BEEF0000);
        chk("rd8_row08_id", 64'(rsp_id), 64'h1);

        // Fairness: both requesters hold valid for six cycles.
        drive(0, 1'b1, 1'b0, 2'd0, 11'h010, 64'h0);
        drive(1, 1'b1, 1'b0, 2'd0, 11'h011, 64'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ready", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) begin
                chk("rr_rsp_id", 64'(rsp_id), 64'((i - 1) % 2));
                chk("rr_rsp_rdata", rsp_rdata, 64'((i - 1) % 2));
            end
            tick();
        end
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("rr_last_valid", 64'(rsp_valid), 64'h1);
        chk("rr_last_id", 64'(rsp_id), 64'h1);
        chk("rr_last_rdata", rsp_rdata, 64'h01);

        // Misaligned word write must not reach the bank.
        drive(0, 1'b1, 1'b1, 2'd2, 11'h006, 64'hDEADBEEF);
        #1;
        chk("mis_ready", 64'(req_ready), 64'h1);
        chk("mis_web", 64'(sram_web), 64'hF);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("mis_valid", 64'(rsp_valid), 64'h1);
        chk("mis_err", 64'(rsp_err), 64'h1);
        chk("mis_rdata", rsp_rdata, 64'h0);
        drive(1, 1'b1, 1'b0, 2'd3, 11'h000, 64'h0);
        tick();
        drive(1, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("mis_row_intact", rsp_rdata, 64'h0);
        chk("mis_row_err", 64'(rsp_err), 64'h0);

        // Write then read of the same byte on consecutive grants.
        drive(0, 1'b1, 1'b1, 2'd0, 11'h021, 64'hAB);
        #1;
        chk("waw_wr_ready", 64'(req_ready), 64'h1);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        drive(1, 1'b1, 1'b0, 2'd0, 11'h021, 64'h0);
        #1;
        chk("waw_rd_ready", 64'(req_ready), 64'h2);
        chk("waw_wr_ack", 64'(rsp_we), 64'h1);
        tick();
        drive(1, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("waw_rdata", rsp_rdata, 64'hAB);
        chk("waw_id", 64'(rsp_id), 64'h1);

        // Reset in the cycle after a grant drops the response and rr.
        drive(0, 1'b1, 1'b0, 2'd3, 11'h010, 64'h0);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_post_valid", 64'(rsp_valid), 64'h0);
        drive(0, 1'b1, 1'b0, 2'd3, 11'h010, 64'h0);
        drive(1, 1'b1, 1'b0, 2'd3, 11'h008, 64'h0);
        #1;
        chk("mid_first_ready", 64'(req_ready), 64'h1);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 11'h0, 64'h0);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("mid_rsp_id", 64'(rsp_id), 64'h0);
        chk("mid_rsp_rdata", rsp_rdata, 64'h0706050403020100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram1rw_arb.md
# sram1rw_arb

Round-robin arbiter and sequencer that shares one `sram1rw` scratchpad bank between `NREQ` requesters. Each requester issues aligned 1/2/4/8-byte reads or writes with a valid/ready handshake. The block grants at most one request per cycle, drives the bank's address, active-low size-encoded write-enable and byte lanes, and returns a fixed-latency response tagged with the requester id. Misaligned or oversized accesses are rejected with an error response and never touch the bank.

## Interface
- `W_WIDTH`, 3: log2 of bank width in bytes; `N = 1<<W_WIDTH`.
- `H_WIDTH`, 8: log2 of bank depth in rows.
- `NREQ`, 2: number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`: requester id width.

Ports:
- `clk` in 1: clock; all logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester grant; one-hot or zero.
- `req_we` in NREQ: 1 = write, 0 = read.
- `req_size` in NREQ*2: log2 of access bytes (0..3), packed per requester.
- `req_addr` in NREQ*(H_WIDTH+W_WIDTH): byte address, packed per requester.
- `req_wdata` in NREQ*8N: write data, right-justified (lane 0 = lowest byte).
- `rsp_valid` out 1: response strobe.
- `rsp_id` out IDW: id of the requester the response belongs to.
- `rsp_we` out 1: response is a write acknowledge.
- `rsp_err` out 1: access was rejected (misaligned or size > W_WIDTH).
- `rsp_rdata` out 8N: read data, right-justified, zero-extended above `1<<size` bytes; 0 for writes and errors.
- `sram_addr` out H_WIDTH+W_WIDTH: to bank `addr`.
- `sram_web` out W_WIDTH+1: to bank `web`, active-low size-encoded.
- `sram_ibyte` out N×8: to bank `ibyte`.
- `sram_obyte` in N×8: from bank `obyte`.

## Operation
- Arbitration:
  - Round-robin pointer `rr` (IDW bits). The winner is the first requester with `req_valid` at index ≥ `rr`, wrapping modulo NREQ.
  - `req_ready[w]=1` is combinational in the grant cycle. Only the winner sees ready.
  - The block grants at most one request per cycle and never stalls: there are no responses to backpressure.
  - After each grant, `rr <= w+1` (wraps to 0 past NREQ-1). With no grant, `rr` holds.
- Legality:
  - An access is legal iff `size <= W_WIDTH` and `addr[size-1:0]==0`.
  - A granted illegal access drives the idle bank signals and is flagged for an error response.
- Bank drive, legal grant:
  - `sram_addr` = winner addr.
  - Read: `sram_web` = all ones.
  - Write: `sram_web` = `~(1<<size)`.
  - `sram_ibyte[k]` = `wdata` byte k for all k. The bank replicates the low `1<<size` bytes across the row.
- Bank drive, idle or illegal: `sram_web` all ones; `sram_addr` holds its last granted value (minimises toggling).
- Response pipeline:
  - One register stage holds valid, id, we, err and size from the grant cycle.
  - `rsp_rdata` = `sram_obyte` lanes 0..(1<<size)-1, masked by the registered size, upper lanes zero.
  - The bank returns data lane-0 aligned, so no shifting is needed.
- Same-address write then read on consecutive grants: the read returns the new data (the bank write completes at the grant edge).

## Timing
- Grant in cycle T (valid & ready at edge T). The bank samples at the end of T. `rsp_*` is valid for exactly one cycle, T+1, for reads, writes and errors alike.
- Throughput: one access per cycle sustained. Back-to-back grants produce back-to-back responses.
- Reset values (while `rst_n=0` and the first cycle after): `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_we=0`, `rsp_err=0`, `rsp_rdata=0`, `rr=0`, `sram_web` all ones, `sram_addr=0`.
- Reset asserted in the cycle after a grant: the pending response is dropped and `rsp_valid=0`.
- `req_valid` may drop without a grant. Requesters must hold their fields stable only in the cycle they are granted.

## Test plan
- Single read after reset: preload addr 0x10 row with bytes 0x00..0x07 via requester 0. Then read size=3, addr=0x10 -> `rsp_valid` at T+1, `rsp_rdata=0x0706050403020100`, `rsp_id=0`.
- Sub-word write/read: write size=1, addr=0x0A, wdata=0xBEEF; read size=1, addr=0x0A -> `rsp_rdata=0x000000000000BEEF`. Read size=3 at 0x08 -> only bytes 2..3 changed.
- Fairness: all NREQ=2 requesters hold valid for 6 cycles -> grants alternate 0,1,0,1,0,1. `rsp_id` follows one cycle later.
- Misaligned access: size=2, addr=0x06 -> `sram_web` all ones in the grant cycle; at T+1 `rsp_err=1`, `rsp_rdata=0`; row contents unchanged.
- Write then read, same address, consecutive cycles: write 0xAB at 0x21 from req 0; read 0x21 size=0 from req 1 -> second response `rsp_rdata=0xAB`.
- Reset mid-stream: assert `rst_n=0` the cycle after a grant -> no `rsp_valid`. After release, the first grant goes to requester 0 (`rr=0`).
